// File: rtl/pe_issue_ctrl_if.sv
// rtl/pe_issue_ctrl_if.sv - control, imem, decoder and execute signals of the PE issue sequencer
interface pe_issue_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] boot_pc;
  logic              halt_req;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic [31:0]       dec_instr;
  logic              dec_complete;
  logic [6:0]        dec_op;
  logic              ex_valid;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_done;
  logic              ex_redirect;
  logic [ADDR_W-1:0] ex_target;
  logic              busy;
  logic              halted;
  logic [1:0]        err_code;
  logic [31:0]       retired_cnt;
  logic [31:0]       stall_cnt;

  modport master (
    input  start, boot_pc, halt_req, imem_rvalid, imem_rdata, dec_complete, dec_op,
           ex_ready, ex_done, ex_redirect, ex_target,
    output imem_req, imem_addr, dec_instr, ex_valid, ex_pc, busy, halted, err_code,
           retired_cnt, stall_cnt
  );

  modport slave (
    output start, boot_pc, halt_req, imem_rvalid, imem_rdata, dec_complete, dec_op,
           ex_ready, ex_done, ex_redirect, ex_target,
    input  imem_req, imem_addr, dec_instr, ex_valid, ex_pc, busy, halted, err_code,
           retired_cnt, stall_cnt
  );
endinterface

// File: rtl/pe_issue_ctrl.sv
// rtl/pe_issue_ctrl.sv - single-issue fetch/decode/execute sequencer for the RISC-V PE front end
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module pe_issue_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEC_TIMEOUT = 8
) (
  input logic            clk,
  input logic            rst,
  pe_issue_ctrl_if.master bus
);
  localparam int TW = $clog2(DEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_EX, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [1:0]        err_q, err_d;
  logic              halt_flag_q, halt_flag_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              start_ok;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

  assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ex_pc_q     <= '0;
      instr_q     <= '0;
      err_q       <= 2'b00;
      halt_flag_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ex_pc_q     <= ex_pc_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      halt_flag_q <= halt_flag_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ex_pc_d     = ex_pc_q;
    instr_d     = instr_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    halt_flag_d = halt_flag_q | bus.halt_req;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d    = bus.boot_pc;
          err_d   = 2'b00;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          tmo_d   = '0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.dec_complete) begin
          if (bus.dec_op == 7'b1110011) begin
            state_d = S_HALT;
          end else if (!op_legal(bus.dec_op)) begin
            err_d   = 2'b01;
            state_d = S_HALT;
          end else begin
            ex_pc_d = pc_q;
            state_d = S_ISSUE;
          end
        end else if (tmo_q == TW'(DEC_TIMEOUT - 1)) begin
          err_d   = 2'b10;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.ex_ready) state_d = S_WAIT_EX;
      end
      S_WAIT_EX: begin
        if (bus.ex_done) begin
          if (bus.ex_redirect && bus.ex_target[1:0] != 2'b00) begin
            err_d   = 2'b11;
            state_d = S_HALT;
          end else begin
            pc_d    = bus.ex_redirect ? bus.ex_target : pc_q + ADDR_W'(4);
            // a request arriving on the boundary cycle itself still counts
            state_d = (halt_flag_q || bus.halt_req) ? S_HALT : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_HALT) halt_flag_d = 1'b0;
  end

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dec_instr = instr_q;
  assign bus.ex_valid  = (state_q == S_ISSUE);
  assign bus.ex_pc     = ex_pc_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted    = (state_q == S_HALT);
  assign bus.err_code  = err_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (start_ok) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == S_WAIT_EX && bus.ex_done && retired_q != 32'hFFFF_FFFF)
        retired_q <= retired_q + 32'd1;
      if (((state_q == S_FETCH && !bus.imem_rvalid) ||
           (state_q == S_ISSUE && !bus.ex_ready)) && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign bus.retired_cnt = 32'd0;
  assign bus.stall_cnt   = 32'd0;
`endif
endmodule
